// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-side hazard controller signal bundle
interface hazard_ctrl_if #(
   parameter int RF_AW = 5,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [RF_AW-1:0] id_rs1_addr;
   logic [RF_AW-1:0] id_rs2_addr;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic             id_reg_wen;
   logic [RF_AW-1:0] id_reg_waddr;
   logic             id_mem_rd;
   logic             ex_take_branch;
   logic             ex_busy;
   logic             pipe_hold;
   logic             id_stall;
   logic             if_flush;
   logic             id2ex_bubble;
   logic             id2ex_op1_forward_from_mem;
   logic             id2ex_op1_forward_from_wb;
   logic             id2ex_op2_forward_from_mem;
   logic             id2ex_op2_forward_from_wb;
   logic [CNT_W-1:0] perf_load_stall_cnt;
   logic [CNT_W-1:0] perf_flush_cnt;

   // pipeline side: presents the ID instruction and EX status
   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             id_reg_wen, id_reg_waddr, id_mem_rd, ex_take_branch, ex_busy,
      input  pipe_hold, id_stall, if_flush, id2ex_bubble,
             id2ex_op1_forward_from_mem, id2ex_op1_forward_from_wb,
             id2ex_op2_forward_from_mem, id2ex_op2_forward_from_wb,
             perf_load_stall_cnt, perf_flush_cnt
   );

   // hazard controller side
   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             id_reg_wen, id_reg_waddr, id_mem_rd, ex_take_branch, ex_busy,
      output pipe_hold, id_stall, if_flush, id2ex_bubble,
             id2ex_op1_forward_from_mem, id2ex_op1_forward_from_wb,
             id2ex_op2_forward_from_mem, id2ex_op2_forward_from_wb,
             perf_load_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, load-use stall, branch flush and busy hold
module hazard_ctrl #(
   parameter int RF_AW = 5,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   // mirrors of the destination state held in ID/EX and EX/MEM
   logic             ex_wen_q, ex_wen_d;
   logic [RF_AW-1:0] ex_waddr_q, ex_waddr_d;
   logic             ex_mem_rd_q, ex_mem_rd_d;
   logic             mem_wen_q;
   logic [RF_AW-1:0] mem_waddr_q;

   // registered forward selects travelling with the instruction into EX
   logic op1_mem_q, op1_wb_q, op2_mem_q, op2_wb_q;
   logic op1_mem_d, op1_wb_d, op2_mem_d, op2_wb_d;

   logic [CNT_W-1:0] load_cnt_q, flush_cnt_q;

   logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
   logic load_use, branch, hold, bubble;

   // source-operand matches against EX and MEM; x0 never matches
   always_comb begin
      rs1_ex  = hz.id_rs1_used & ex_wen_q  & (ex_waddr_q  == hz.id_rs1_addr) & (hz.id_rs1_addr != '0);
      rs2_ex  = hz.id_rs2_used & ex_wen_q  & (ex_waddr_q  == hz.id_rs2_addr) & (hz.id_rs2_addr != '0);
      rs1_mem = hz.id_rs1_used & mem_wen_q & (mem_waddr_q == hz.id_rs1_addr) & (hz.id_rs1_addr != '0);
      rs2_mem = hz.id_rs2_used & mem_wen_q & (mem_waddr_q == hz.id_rs2_addr) & (hz.id_rs2_addr != '0);
   end

   // pipeline control: busy beats branch, branch beats load-use
   always_comb begin
      hold     = hz.ex_busy;
      branch   = ~hold & hz.ex_take_branch;
      load_use = ~hold & hz.id_valid & (rs1_ex | rs2_ex) & ex_mem_rd_q;
      bubble   = branch | load_use;
   end

   assign hz.pipe_hold    = hold;
   assign hz.if_flush     = branch;
   assign hz.id_stall     = load_use & ~branch;
   assign hz.id2ex_bubble = bubble;

   // next mirror and forward-select state for an unheld advance
   always_comb begin
      ex_wen_d    = hz.id_reg_wen & hz.id_valid;
      ex_waddr_d  = hz.id_reg_waddr;
      ex_mem_rd_d = hz.id_mem_rd & hz.id_valid;
      // a load in EX cannot be forwarded from MEM; that case is bubbled instead
      op1_mem_d   = rs1_ex & ~ex_mem_rd_q;
      op2_mem_d   = rs2_ex & ~ex_mem_rd_q;
      op1_wb_d    = ~op1_mem_d & rs1_mem;
      op2_wb_d    = ~op2_mem_d & rs2_mem;
      if (bubble) begin
         ex_wen_d    = 1'b0;
         ex_waddr_d  = ex_waddr_q;
         ex_mem_rd_d = 1'b0;
         op1_mem_d   = 1'b0;
         op2_mem_d   = 1'b0;
         op1_wb_d    = 1'b0;
         op2_wb_d    = 1'b0;
      end
   end

   // mirror, flag and counter registers; everything freezes while EX is busy
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_wen_q    <= 1'b0;
         ex_waddr_q  <= '0;
         ex_mem_rd_q <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_waddr_q <= '0;
         op1_mem_q   <= 1'b0;
         op1_wb_q    <= 1'b0;
         op2_mem_q   <= 1'b0;
         op2_wb_q    <= 1'b0;
         load_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else if (!hold) begin
         mem_wen_q   <= ex_wen_q;
         mem_waddr_q <= ex_waddr_q;
         ex_wen_q    <= ex_wen_d;
         ex_waddr_q  <= ex_waddr_d;
         ex_mem_rd_q <= ex_mem_rd_d;
         op1_mem_q   <= op1_mem_d;
         op1_wb_q    <= op1_wb_d;
         op2_mem_q   <= op2_mem_d;
         op2_wb_q    <= op2_wb_d;
         if (load_use && !branch && load_cnt_q != '1)
            load_cnt_q <= load_cnt_q + CNT_W'(1);
         if (branch && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign hz.id2ex_op1_forward_from_mem = op1_mem_q;
   assign hz.id2ex_op1_forward_from_wb  = op1_wb_q;
   assign hz.id2ex_op2_forward_from_mem = op2_mem_q;
   assign hz.id2ex_op2_forward_from_wb  = op2_wb_q;
   assign hz.perf_load_stall_cnt        = load_cnt_q;
   assign hz.perf_flush_cnt             = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed-vector bench for hazard_ctrl
module tb_hazard_ctrl;
   localparam int RF_AW = 5;
   localparam int CNT_W = 4;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   hazard_ctrl_if #(.RF_AW(RF_AW), .CNT_W(CNT_W)) hz ();

   hazard_ctrl #(.RF_AW(RF_AW), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic wen,
                         input logic [4:0] wd, input logic mrd);
      hz.id_valid     = v;
      hz.id_rs1_addr  = r1;
      hz.id_rs1_used  = u1;
      hz.id_rs2_addr  = r2;
      hz.id_rs2_used  = u2;
      hz.id_reg_wen   = wen;
      hz.id_reg_waddr = wd;
      hz.id_mem_rd    = mrd;
   endtask

   task automatic chk_ctrl(input string tag, input logic hold, input logic stall,
                           input logic flush, input logic bub);
      chk({tag, "_hold"},  hz.pipe_hold,    hold);
      chk({tag, "_stall"}, hz.id_stall,     stall);
      chk({tag, "_flush"}, hz.if_flush,     flush);
      chk({tag, "_bub"},   hz.id2ex_bubble, bub);
   endtask

   task automatic chk_fwd(input string tag, input logic m1, input logic w1,
                          input logic m2, input logic w2);
      chk({tag, "_op1mem"}, hz.id2ex_op1_forward_from_mem, m1);
      chk({tag, "_op1wb"},  hz.id2ex_op1_forward_from_wb,  w1);
      chk({tag, "_op2mem"}, hz.id2ex_op2_forward_from_mem, m2);
      chk({tag, "_op2wb"},  hz.id2ex_op2_forward_from_wb,  w2);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      hz.ex_take_branch = 1'b0;
      hz.ex_busy        = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk_ctrl("reset", 0, 0, 0, 0);
      chk_fwd("reset", 0, 0, 0, 0);
      chk("reset_lcnt", 32'(hz.perf_load_stall_cnt), 0);
      chk("reset_fcnt", 32'(hz.perf_flush_cnt), 0);

      // ALU back-to-back: addi x5,x0 ; add x6,x5,x5
      id_set(1, 0, 1, 0, 0, 1, 5, 0);
      tick();
      id_set(1, 5, 1, 5, 1, 1, 6, 0);
      #1;
      chk_ctrl("b2b", 0, 0, 0, 0);
      tick();
      chk_fwd("b2b", 1, 0, 1, 0);

      // distance 2: addi x5 ; nop ; add x6,x5,x0
      id_set(1, 0, 1, 0, 0, 1, 5, 0);
      tick();
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      id_set(1, 5, 1, 0, 1, 1, 6, 0);
      tick();
      chk_fwd("dist2", 0, 1, 0, 0);

      // load-use: lw x7,(x2) ; add x8,x7,x1
      id_set(1, 2, 1, 0, 0, 1, 7, 1);
      tick();
      id_set(1, 7, 1, 1, 1, 1, 8, 0);
      #1;
      chk_ctrl("lu", 0, 1, 0, 1);
      tick();
      chk("lu_lcnt", 32'(hz.perf_load_stall_cnt), 1);
      chk_ctrl("lu_after", 0, 0, 0, 0);
      chk_fwd("lu_bub", 0, 0, 0, 0);
      tick();
      chk_fwd("lu_dep", 0, 1, 0, 0);

      // branch coincident with load-use: lw x9 ; add x10,x9,x9 + taken branch
      id_set(1, 2, 1, 0, 0, 1, 9, 1);
      tick();
      id_set(1, 9, 1, 9, 1, 1, 10, 0);
      hz.ex_take_branch = 1'b1;
      #1;
      chk_ctrl("brlu", 0, 0, 1, 1);
      tick();
      hz.ex_take_branch = 1'b0;
      chk("brlu_fcnt", 32'(hz.perf_flush_cnt), 1);
      chk("brlu_lcnt", 32'(hz.perf_load_stall_cnt), 1);
      chk_fwd("brlu", 0, 0, 0, 0);

      // busy for 5 cycles with addi x5 in EX and add x6,x5,x5 in ID
      id_set(1, 0, 1, 0, 0, 1, 5, 0);
      tick();
      id_set(1, 5, 1, 5, 1, 1, 6, 0);
      hz.ex_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         hz.ex_take_branch = (i == 2);
         #1;
         chk_ctrl("busy", 1, 0, 0, 0);
         tick();
         chk_fwd("busy", 0, 0, 0, 0);
      end
      hz.ex_busy        = 1'b0;
      hz.ex_take_branch = 1'b0;
      #1;
      chk_ctrl("unbusy", 0, 0, 0, 0);
      chk("busy_fcnt", 32'(hz.perf_flush_cnt), 1);
      tick();
      chk_fwd("unbusy", 1, 0, 1, 0);

      // flush counter saturation: 20 more flushes from 1 -> 15
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
      hz.ex_take_branch = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("sat_mid", 32'(hz.perf_flush_cnt), 6);
      for (int i = 0; i < 15; i++) tick();
      chk("sat_end", 32'(hz.perf_flush_cnt), 15);
      hz.ex_take_branch = 1'b0;

      // reset during a load-use stall
      id_set(1, 2, 1, 0, 0, 1, 7, 1);
      tick();
      id_set(1, 7, 1, 1, 1, 1, 8, 0);
      #1;
      chk("rst_pre_stall", hz.id_stall, 1);
      rst = 1'b1;
      tick();
      chk_ctrl("rst", 0, 0, 0, 0);
      chk_fwd("rst", 0, 0, 0, 0);
      chk("rst_lcnt", 32'(hz.perf_load_stall_cnt), 0);
      chk("rst_fcnt", 32'(hz.perf_flush_cnt), 0);
      rst = 1'b0;
      #1;
      chk("rst_after_stall", hz.id_stall, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It sits beside the ID stage and mirrors the destination-register state of the ID/EX and EX/MEM pipe registers. From that state it generates the registered forwarding selects consumed by EX (`id2ex_op*_forward_from_mem/wb`), load-use stall bubbles, taken-branch flushes and full-pipeline holds for multi-cycle EX operations. It also keeps two saturating performance counters.

## Interface

Parameters:
- `RF_AW`, default 5: register-file address width.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1_addr`, `id_rs2_addr` in RF_AW: source registers of the ID instruction.
- `id_rs1_used`, `id_rs2_used` in 1: the instruction actually reads rs1 / rs2.
- `id_reg_wen` in 1: the ID instruction writes rd.
- `id_reg_waddr` in RF_AW: rd of the ID instruction.
- `id_mem_rd` in 1: the ID instruction is a load.
- `ex_take_branch` in 1: EX resolved a taken branch or jump this cycle.
- `ex_busy` in 1: a multi-cycle EX operation is in progress.
- `pipe_hold` out 1: freeze every pipe register (IF through MEM/WB).
- `id_stall` out 1: hold the PC and IF/ID.
- `if_flush` out 1: kill IF/ID contents.
- `id2ex_bubble` out 1: load a NOP into ID/EX (reg_wen=0, mem_rd=0, mem_wr=0, br_instr=0).
- `id2ex_op1_forward_from_mem`, `id2ex_op1_forward_from_wb`, `id2ex_op2_forward_from_mem`, `id2ex_op2_forward_from_wb` out 1 each: registered forward selects, part of ID/EX.
- `perf_load_stall_cnt`, `perf_flush_cnt` out CNT_W: saturating event counters.

## Operation

- Internal mirrors:
  - `ex_wen`, `ex_waddr`, `ex_mem_rd` track the instruction in ID/EX.
  - `mem_wen`, `mem_waddr` track the instruction in EX/MEM.
- Match definitions:
  - `rsN` matches EX when `id_rsN_used & ex_wen & ex_waddr==id_rsN_addr & id_rsN_addr!=0`.
  - MEM matches are defined the same way using `mem_*`.
  - x0 never matches.
- Load-use: `id_valid`, an rs1 or rs2 match against EX, and `ex_mem_rd` → `id_stall=1`, `id2ex_bubble=1` for exactly one cycle. After the bubble the load sits in MEM/WB, so the dependent instruction gets `from_wb`.
- Forward select computation, per operand, latched into the flags on advance:
  - EX match with a non-load → `from_mem=1`.
  - Otherwise a MEM match → `from_wb=1`.
  - Otherwise both 0.
  - `from_mem` has priority over `from_wb`, so both are never 1 together.
  - Instructions three or more ahead are served by the register file; its write-through is the register file's concern.
- Taken branch: `ex_take_branch` → `if_flush=1` and `id2ex_bubble=1` in the same cycle. It overrides a simultaneous load-use stall; `id_stall=0` because the PC loads the target.
- Priority: `ex_busy` > `ex_take_branch` > load-use > normal.
  - `ex_busy=1` → `pipe_hold=1`. All other control outputs are 0, and mirrors, flags and counters hold.
  - A branch asserted during busy is ignored; EX re-presents it once busy drops.
- Mirror and flag update each cycle when not held:
  - Bubble: `ex_wen<=0`, `ex_mem_rd<=0`, flags<=0.
  - Normal: `ex_* <= id_* & id_valid`, flags<=computed.
  - In both cases `mem_* <= ex_*` (before update).
- Counters:
  - `perf_load_stall_cnt` increments on each load-use bubble that is not overridden by a branch.
  - `perf_flush_cnt` increments on each unheld `ex_take_branch`.
  - Both saturate at all-ones.

## Timing

- Reset: every output, mirror, flag and counter is 0.
- `pipe_hold`, `id_stall`, `if_flush`, `id2ex_bubble` are combinational from current inputs and mirrors; zero latency.
- Forward flags are registered: computed in the cycle the consumer is in ID, valid during its EX cycle.
- A load-use stall lasts exactly 1 cycle, since the next cycle `ex_mem_rd=0`.
- A branch flush costs 2 instructions (IF/ID and ID), signalled in 1 cycle.
- Reset asserted mid-stall or mid-busy clears everything on the next edge; no residual stall.

## Test plan

- ALU back-to-back: `addi x5` followed by `add x6,x5,x5` → the cycle after, `op1_forward_from_mem=1` and `op2_forward_from_mem=1`; no stall.
- Distance 2: `addi x5`, `nop`, `add x6,x5,x0` → `op1_forward_from_wb=1`, `op2` flags 0 (x0 read but x0 is never forwarded).
- Load-use: `lw x7` then `add x8,x7,x1` → one cycle `id_stall=1`, `id2ex_bubble=1`; the add then gets `op1_forward_from_wb=1`; `perf_load_stall_cnt=1`.
- Branch coincident with load-use: `ex_take_branch=1` while load-use is active → `if_flush=1`, `id_stall=0`, `perf_flush_cnt=1`, `perf_load_stall_cnt` unchanged.
- Busy: `ex_busy` high for 5 cycles with a dependent pair in flight → `pipe_hold=1` for 5 cycles, flags unchanged; after release the forwards match the unheld case.
- Saturation and reset: with `CNT_W=4`, 20 flushes → `perf_flush_cnt=15`; `rst` during a stall → all outputs 0 the next cycle.
